nn_class_reader: RTL and testbench

- Output-side consumer of the two-layer classifier: reads the 10 signed layer-2 scores once the layer-2 counter reports done.
- Scans the scores serially, one per cycle, and finds the winning class, its score and the margin over the runner-up.
- Presents the result through a valid/ready handshake to downstream logic (display, UART reporter).
- Together with the network's done signalling, it forms the result-transfer path out of the neural-network top.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/nn_argmax_step.sv | 49 ++++
 rtl/nn_class_reader.sv | 140 ++++++++++++++
 tb/tb_nn_class_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Brief    : Shared types and sizes for the neural-network result path.
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NN_NUM_CLASSES = 10;
    localparam int NN_OUT_BITS    = 48;

    typedef logic signed [NN_OUT_BITS-1:0] nn_score_t;
    typedef logic        [3:0]             nn_class_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_argmax_step.sv
`default_nettype none
// ============================================================================
// Module   : nn_argmax_step
// Brief    : Combinational single-candidate update of the running
//            (best, best_idx, second) triple. Strictly-greater replaces the
//            best, so on ties the earlier (lower) index keeps the win and the
//            equal value becomes the runner-up.
// Revision : 1.0 - initial release
// ============================================================================
module nn_argmax_step
    import nn_pkg::*;
#(
    parameter int DATA_BITS = NN_OUT_BITS,
    parameter int IDX_BITS  = 4
) (
    input  logic                        first,
    input  logic signed [DATA_BITS-1:0] cand,
    input  logic        [IDX_BITS-1:0]  cand_idx,
    input  logic signed [DATA_BITS-1:0] best_in,
    input  logic        [IDX_BITS-1:0]  best_idx_in,
    input  logic signed [DATA_BITS-1:0] second_in,
    output logic signed [DATA_BITS-1:0] best_out,
    output logic        [IDX_BITS-1:0]  best_idx_out,
    output logic signed [DATA_BITS-1:0] second_out
);

    // Runner-up seed: anything real compares greater-or-equal to this.
    localparam logic signed [DATA_BITS-1:0] c_MOST_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};

    // One signed compare step; the first candidate seeds the triple.
    always_comb begin
        best_out     = best_in;
        best_idx_out = best_idx_in;
        second_out   = second_in;
        if (first) begin
            best_out     = cand;
            best_idx_out = cand_idx;
            second_out   = c_MOST_NEG;
        end else if (cand > best_in) begin
            second_out   = best_in;
            best_out     = cand;
            best_idx_out = cand_idx;
        end else if (cand > second_in) begin
            second_out   = cand;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nn_class_reader.sv
`default_nettype none
// ============================================================================
// Module   : nn_class_reader
// Brief    : Snapshots the layer-2 scores on a rising done_in, scans them one
//            per cycle for the winning class, its score and its margin over
//            the runner-up, and offers the result on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nn_class_reader
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NN_NUM_CLASSES,
    parameter int DATA_BITS   = NN_OUT_BITS,
    parameter int IDX_BITS    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done_in,
    input  logic signed [DATA_BITS-1:0] scores [0:NUM_CLASSES-1],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [IDX_BITS-1:0]  class_idx,
    output logic signed [DATA_BITS-1:0] class_score,
    output logic        [DATA_BITS:0]   margin,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [IDX_BITS-1:0] c_LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

    reader_state_t               r_state;
    logic                        r_done_q;
    logic signed [DATA_BITS-1:0] r_snap [0:NUM_CLASSES-1];
    logic        [IDX_BITS-1:0]  r_idx;
    logic signed [DATA_BITS-1:0] r_best;
    logic        [IDX_BITS-1:0]  r_best_idx;
    logic signed [DATA_BITS-1:0] r_second;

    logic                        w_start;
    logic signed [DATA_BITS-1:0] w_best;
    logic        [IDX_BITS-1:0]  w_best_idx;
    logic signed [DATA_BITS-1:0] w_second;
    logic        [DATA_BITS:0]   w_margin;

    // done_q resets high so a done_in already asserted at reset release is
    // not mistaken for a fresh completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_q <= 1'b1;
        end else begin
            r_done_q <= done_in;
        end
    end

    assign w_start = done_in & ~r_done_q;

    nn_argmax_step #(
        .DATA_BITS (DATA_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_step (
        .first        (r_idx == '0),
        .cand         (r_snap[r_idx]),
        .cand_idx     (r_idx),
        .best_in      (r_best),
        .best_idx_in  (r_best_idx),
        .second_in    (r_second),
        .best_out     (w_best),
        .best_idx_out (w_best_idx),
        .second_out   (w_second)
    );

    // Sign-extend by one bit so the full signed range difference fits.
    assign w_margin = {w_best[DATA_BITS-1], w_best} - {w_second[DATA_BITS-1], w_second};

    // Reader FSM: snapshot, serial scan, then hold the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_second    <= '0;
            out_valid   <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            margin      <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            r_snap[i] <= scores[i];
                        end
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_start) begin
                        overrun <= 1'b1;
                    end
                    r_best     <= w_best;
                    r_best_idx <= w_best_idx;
                    r_second   <= w_second;
                    if (r_idx == c_LAST_IDX) begin
                        class_idx   <= w_best_idx;
                        class_score <= w_best;
                        margin      <= w_margin;
                        out_valid   <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_idx <= r_idx + IDX_BITS'(1);
                    end
                end
                HOLD: begin
                    if (w_start) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_class_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_class_reader
// Brief    : Table-driven self-checking bench with a result scoreboard for
//            nn_class_reader, plus backpressure, overrun and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_class_reader;

    localparam int N = 10;
    localparam int W = 48;

    typedef struct {
        logic signed [W-1:0] s [0:N-1];
        logic        [3:0]   idx;
        logic signed [W-1:0] score;
        logic        [W:0]   mar;
    } vec_t;

    typedef struct {
        logic        [3:0]   idx;
        logic signed [W-1:0] score;
        logic        [W:0]   mar;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                done_in;
    logic signed [W-1:0] scores [0:N-1];
    logic                out_valid;
    logic                out_ready;
    logic        [3:0]   class_idx;
    logic signed [W-1:0] class_score;
    logic        [W:0]   margin;
    logic                busy;
    logic                overrun;

    exp_t sb [$];
    vec_t tv [6];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    nn_class_reader #(
        .NUM_CLASSES (N),
        .DATA_BITS   (W),
        .IDX_BITS    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .scores      (scores),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .class_score (class_score),
        .margin      (margin),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.idx   = v.idx;
        e.score = v.score;
        e.mar   = v.mar;
        sb.push_back(e);
    endtask

    // Compare the offered result against the oldest expectation.
    task automatic consume(input string nm);
        exp_t e;
        if (!out_valid) begin
            chk({nm, " valid"}, {63'd0, out_valid}, 64'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk({nm, " unexpected result"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, " class_idx"}, {60'd0, class_idx}, {60'd0, e.idx});
            chk({nm, " class_score"}, 64'(class_score), 64'(e.score));
            chk({nm, " margin"}, {15'd0, margin}, {15'd0, e.mar});
        end
    endtask

    task automatic start_read(input vec_t v);
        scores  = v.s;
        done_in = 1'b0;
        @(posedge clk);
        #1 done_in = 1'b1;
    endtask

    // Wait (bounded) for out_valid; optionally scramble inputs after start.
    task automatic wait_valid(input bit scramble, output int cnt, output bit busy_ok);
        cnt     = 0;
        busy_ok = 1'b1;
        while (cnt < 40) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1) done_in = 1'b0;
            if (scramble && cnt <= 5) begin
                for (int i = 0; i < N; i++) scores[i] = W'({$urandom(), $urandom()});
            end
            @(negedge clk);
            if (out_valid) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cnt;
        bit bok;
        start_read(v);
        push_exp(v);
        wait_valid(1'b1, cnt, bok);
        chk({nm, " latency"}, 64'(cnt), 64'd11);
        chk({nm, " busy in scan"}, {63'd0, bok}, 64'd1);
        chk({nm, " busy in hold"}, {63'd0, busy}, 64'd1);
        consume(nm);
        @(negedge clk);
        chk({nm, " valid drop"}, {63'd0, out_valid}, 64'd0);
        chk({nm, " idx held"}, {60'd0, class_idx}, {60'd0, v.idx});
    endtask

    initial begin
        int  cnt;
        bit  bok;
        bit  stable;
        int  ovr;
        bit  quiet;

        tv[0].s = '{48'sd5, -48'sd3, 48'sd100, 48'sd7, 48'sd0, 48'sd2, 48'sd99, -48'sd50, 48'sd1, 48'sd4};
        tv[0].idx = 4'd2; tv[0].score = 48'sd100; tv[0].mar = 49'd1;
        for (int i = 0; i < N; i++) tv[1].s[i] = -48'sd10;
        tv[1].s[7] = -48'sd2;
        tv[1].idx = 4'd7; tv[1].score = -48'sd2; tv[1].mar = 49'd8;
        for (int i = 0; i < N; i++) tv[2].s[i] = 48'sd3;
        tv[2].idx = 4'd0; tv[2].score = 48'sd3; tv[2].mar = 49'd0;
        for (int i = 0; i < N; i++) tv[3].s[i] = {1'b1, 47'd0};
        tv[3].s[4] = {1'b0, {47{1'b1}}};
        tv[3].idx = 4'd4; tv[3].score = {1'b0, {47{1'b1}}}; tv[3].mar = {1'b0, {48{1'b1}}};
        tv[4].s = '{-48'sd1, 48'sd9, 48'sd2, 48'sd9, 48'sd0, 48'sd0, 48'sd0, 48'sd0, 48'sd0, -48'sd5};
        tv[4].idx = 4'd1; tv[4].score = 48'sd9; tv[4].mar = 49'd0;
        for (int i = 0; i < N; i++) tv[5].s[i] = W'(i);
        tv[5].idx = 4'd9; tv[5].score = 48'sd9; tv[5].mar = 49'd1;

        // Reset state, with done_in already high across reset release.
        rst       = 1'b1;
        done_in   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) scores[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset overrun", {63'd0, overrun}, 64'd0);
        chk("reset class_idx", {60'd0, class_idx}, 64'd0);
        chk("reset class_score", 64'(class_score), 64'd0);
        chk("reset margin", {15'd0, margin}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy) quiet = 1'b0;
        end
        chk("no start on held done", {63'd0, quiet}, 64'd1);

        // Main table.
        run_vec(tv[0], "peak100");
        run_vec(tv[1], "neg7");
        run_vec(tv[2], "alleq");
        run_vec(tv[3], "extreme");
        run_vec(tv[4], "tie");
        run_vec(tv[5], "last");

        // Backpressure with a start edge arriving during HOLD.
        out_ready = 1'b0;
        start_read(tv[0]);
        push_exp(tv[0]);
        wait_valid(1'b0, cnt, bok);
        chk("bp latency", 64'(cnt), 64'd11);
        stable = 1'b1;
        ovr    = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) done_in = 1'b1;
            @(negedge clk);
            if (overrun) ovr++;
            if (!out_valid || class_idx !== 4'd2 || class_score !== 48'sd100 || margin !== 49'd1)
                stable = 1'b0;
        end
        chk("bp stable", {63'd0, stable}, 64'd1);
        chk("bp overrun pulses", 64'(ovr), 64'd1);
        out_ready = 1'b1;
        consume("bp");
        @(negedge clk);
        chk("bp valid drop", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("bp idle busy", {63'd0, busy}, 64'd0);

        // Reset during SCAN with done_in left high.
        start_read(tv[1]);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort class_idx", {60'd0, class_idx}, 64'd0);
        chk("abort class_score", 64'(class_score), 64'd0);
        chk("abort margin", {15'd0, margin}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (busy || out_valid) quiet = 1'b0;
        end
        chk("abort no restart", {63'd0, quiet}, 64'd1);
        run_vec(tv[2], "after abort");

        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
